// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width for a given operand width (never below 1 bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full-subtractor cell: diff = a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start, result outputs hold
// SHIFT | one bit per clock through the full-subtractor cell
// DONE  | one-cycle done pulse; start here begins the next operation
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             bit_diff, bit_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .diff (bit_diff),
    .bout (bit_bout)
  );

  assign res_shift = {bit_diff, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          count_d  = '0;
          res_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = res_shift;
        borrow_d = bit_bout;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
          // Final diff bit is the result MSB, available in this same cycle.
          ovf_d   = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int TMO = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done, bout;
  logic [W-1:0] diff;
  int           checks = 0;
  int           errors = 0;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`else
  logic ovf;
  assign ovf = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: unsigned subtraction and two's-complement overflow rule.
  task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                         output logic [W-1:0] rd, output logic rbo, output logic rov);
    longint unsigned ua, ub, t;
    ua  = longint'(ra);
    ub  = longint'(rb) + longint'(rbin);
    t   = ua - ub;
    rd  = W'(t);
    rbo = (ua < ub);
    rov = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
  endtask

  // Drives one operation and waits (bounded) for done; no comparisons here.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                        output logic [W-1:0] rd, output logic rb, output logic ro,
                        output int lat);
    @(negedge clk);
    a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = diff; rb = bout; ro = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b bout=%b diff=%h", ready, busy, done, bout, diff);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d; logic bo, ov; int lat;
    run_op(8'h5A, 8'h23, 1'b0, d, bo, ov, lat);
    checks++;
    if (lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, W);
    end
    checks++;
    if (d !== 8'h37 || bo !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got diff=%h bout=%b want 37/0", d, bo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || diff !== 8'h37) begin
      errors++;
      $display("FAIL done_width: got done=%b ready=%b diff=%h want 0/1/37", done, ready, diff);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [4] = '{8'h00, 8'h00, 8'hA5, 8'hFF};
    logic [W-1:0] tb [4] = '{8'h01, 8'h00, 8'hA5, 8'h00};
    logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ed [4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    logic         eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] d; logic bo, ov; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], d, bo, ov, lat);
      checks++;
      if (lat !== W || d !== ed[i] || bo !== eb[i]) begin
        errors++;
        $display("FAIL boundary_%0d: got diff=%h bout=%b lat=%0d want %h/%b/%0d",
                 i, d, bo, lat, ed[i], eb[i], W);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL busy_flags_%0d: got ready=%b busy=%b done=%b want 0/1/0", i, ready, busy, done);
      end
      @(negedge clk);
      a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'h37 || bout !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: got done=%b diff=%h bout=%b want 1/37/0", done, diff, bout);
    end
    lat = 0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_queue: got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d; logic bo, ov; int lat;
    run_op(8'h5A, 8'h23, 1'b0, d, bo, ov, lat);
    @(negedge clk);
    a = 8'h10; b = 8'h10; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || diff !== 8'h37) begin
      errors++;
      $display("FAIL b2b_hold: got busy=%b diff=%h want 1/37", busy, diff);
    end
    lat = 1;
    while (done !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== W + 1 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got gap=%0d diff=%h bout=%b want %0d/00/0", lat, diff, bout, W + 1);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] d; logic bo, ov; int lat; int seen;
    @(negedge clk);
    a = 8'h11; b = 8'h22; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL abort_state: got rdy=%b busy=%b done=%b bout=%b diff=%h", ready, busy, done, bout, diff);
    end
    seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        @(negedge clk) rst_n = 1'b1;
      end
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
    end
    run_op(8'h80, 8'h01, 1'b0, d, bo, ov, lat);
    checks++;
    if (lat !== W || d !== 8'h7F || bo !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: got diff=%h bout=%b lat=%0d want 7F/0/%0d", d, bo, lat, W);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, d, ed; logic rc, bo, ov, eb, eo; int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_sub(ra, rb, rc, ed, eb, eo);
      run_op(ra, rb, rc, d, bo, ov, lat);
      checks++;
      if (lat !== W || d !== ed || bo !== eb) begin
        errors++;
        $display("FAIL random_%0d: %h-%h-%b got diff=%h bout=%b lat=%0d want %h/%b/%0d",
                 i, ra, rb, rc, d, bo, lat, ed, eb, W);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ov !== eo) begin
        errors++;
        $display("FAIL random_ovf_%0d: %h-%h-%b got %b want %b", i, ra, rb, rc, ov, eo);
      end
`endif
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] ta [3] = '{8'h80, 8'h7F, 8'h05};
    logic [W-1:0] tb [3] = '{8'h01, 8'hFF, 8'h03};
    logic [W-1:0] ed [3] = '{8'h7F, 8'h80, 8'h02};
    logic         eo [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] d; logic bo, ov; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, d, bo, ov, lat);
      checks++;
      if (ov !== eo[i] || d !== ed[i]) begin
        errors++;
        $display("FAIL ovf_%0d: got ovf=%b diff=%h want %b/%h", i, ov, d, eo[i], ed[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor with borrow-in: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single 1-bit full-subtractor cell and a registered borrow.
- It is the subtract-direction counterpart of the team's full-adder arithmetic cells.
- Sits beside the combinational adder/subtractor blocks as the area-minimal option for datapaths that can tolerate multi-cycle latency, using a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a clock edge where ready=1
- a  input  WIDTH  minuend; sampled on the accepting edge only
- b  input  WIDTH  subtrahend; sampled on the accepting edge only
- bin  input  1  borrow-in; sampled on the accepting edge only
- ready  output  1  block can accept start (state IDLE or DONE)
- busy  output  1  state SHIFT
- done  output  1  one-cycle pulse; diff and bout valid
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH
- bout  output  1  final borrow; 1 when a < b + bin (unsigned)

Behaviour:
- Clock and reset: single clock domain, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, internal shift registers=0, bit counter=0, borrow register=0.
- States:
  - IDLE -> SHIFT on start.
  - SHIFT -> SHIFT while count < WIDTH-1; SHIFT -> DONE when count = WIDTH-1.
  - DONE -> SHIFT on start; otherwise DONE -> IDLE.
- Accepting edge (start=1 and ready=1):
  - load a_sr=a, b_sr=b, borrow=bin, count=0.
  - clear the result shift register.
- Each SHIFT edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - shift a_sr and b_sr right by 1; shift d into the MSB of the result register; count += 1.
- Latency: done=1 in the cycle after the WIDTH-th SHIFT edge, i.e. WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+1 cycles; back-to-back is allowed by asserting start during DONE.
- done is high only in state DONE, so it is exactly one cycle wide.
- diff and bout are registered. They update on the edge entering DONE and hold until the next entry to DONE; they do not change during a following SHIFT.
- start while busy=1 is ignored; there is no queuing.
- Input changes on a, b, bin outside the accepting edge have no effect.
- rst_n low mid-operation aborts immediately to reset values; no done pulse is produced for the aborted operation.
- Boundaries:
  - a = b with bin=0 gives diff=0, bout=0.
  - a=0, b=0, bin=1 gives diff=all-ones, bout=1.
  - a=all-ones, b=0, bin=0 gives no borrow.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - extra output port ovf (1 bit, registered, reset 0), valid with done.
  - ovf=1 when the two's-complement signed subtraction overflows: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - the MSBs of a and b are captured on the accepting edge.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum typedef (IDLE, SHIFT, DONE).
  - counter width constant CNT_W = $clog2(WIDTH).
  - default WIDTH constant.
- One natural sub-module: full_subtractor, a 1-bit combinational cell with inputs a, b, bin and outputs diff, bout, instantiated once for the serial bit datapath.

Test Plan:
- Reset, then start with a=8'h5A, b=8'h23, bin=0 -> done 8 edges later; diff=8'h37, bout=0; done exactly 1 cycle.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1.
- start pulses during busy with a=8'hFF -> ignored; the first operation's result is unchanged; ready=0 throughout SHIFT.
- Back-to-back: start asserted in the DONE cycle with a=8'h10, b=8'h10 -> second done 9 cycles after the first; diff=8'h00, bout=0.
- rst_n asserted low at SHIFT bit 4 -> outputs immediately at reset values; no done; a subsequent operation a=8'h80, b=8'h01 gives diff=8'h7F.
- SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01 -> ovf=1. a=8'h7F, b=8'hFF -> ovf=1, diff=8'h80. a=8'h05, b=8'h03 -> ovf=0.
